// File: rtl/board_detect_if.sv
// Board-detection result bus.
//
// Carries the software rescan request into the detection engine and the
// detection results back out to the chan-0 register mux.
//
//   master : the detection engine (drives results, receives rescan)
//   slave  : the register mux / consumer (drives rescan, reads results)
//
// Signals
//   rescan       1-cycle pulse, restart detection
//   busy         engine is settling, sampling or matching
//   done         detection finished, results valid (level)
//   match_vec    bit k set when the snapshot satisfies signature k
//   board_valid  at least one signature matched, qualified by done
//   board_type   lowest matching signature index, else 0
//   ambiguous    more than one signature matched
//   stable_err   IO lines never settled within the timeout
//   io_snapshot  latched stable IO value
//   scan_count   completed scans, saturating at 255
//   changed      sticky recheck-mismatch flag (0 when recheck is not built)
interface board_detect_if #(
    parameter int IO_WIDTH   = 74,
    parameter int NUM_BOARDS = 4
);
    localparam int TYPE_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    logic                  rescan;
    logic                  busy;
    logic                  done;
    logic [NUM_BOARDS-1:0] match_vec;
    logic                  board_valid;
    logic [TYPE_W-1:0]     board_type;
    logic                  ambiguous;
    logic                  stable_err;
    logic [IO_WIDTH-1:0]   io_snapshot;
    logic [7:0]            scan_count;
    logic                  changed;

    modport master (
        input  rescan,
        output busy, done, match_vec, board_valid, board_type, ambiguous,
               stable_err, io_snapshot, scan_count, changed
    );

    modport slave (
        output rescan,
        input  busy, done, match_vec, board_valid, board_type, ambiguous,
               stable_err, io_snapshot, scan_count, changed
    );
endinterface

// File: rtl/board_detect_scan.sv
// Timed board-detection engine.
//
// Synchronises the J1/J2 IO lines, waits a settle period, then waits for
// STABLE_SAMPLES consecutive identical samples before matching the captured
// snapshot against run-time zero/one signature masks. Signature 0 has the
// highest priority. Software can restart detection with a rescan pulse.
//
// Ports
//   sysclk      system clock
//   reset_n     asynchronous active-low reset
//   io_in       raw IO pins (asynchronous to sysclk)
//   zero_masks  slice k: bits that must read 0 for board k
//   one_masks   slice k: bits that must read 1 for board k
//   bus         result bus (master side), see board_detect_if
//
// Optional feature: define BOARD_DETECT_RECHECK_EN to periodically re-sample
// the IO lines in DONE and raise the sticky 'changed' flag if they no longer
// agree with the snapshot. Without it 'changed' is tied low.
module board_detect_scan #(
    parameter int IO_WIDTH       = 74,
    parameter int NUM_BOARDS     = 4,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int STABLE_SAMPLES = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RECHECK_CYCLES = 1 << 20
) (
    input  logic                             sysclk,
    input  logic                             reset_n,
    input  logic [IO_WIDTH-1:0]              io_in,
    input  logic [NUM_BOARDS*IO_WIDTH-1:0]   zero_masks,
    input  logic [NUM_BOARDS*IO_WIDTH-1:0]   one_masks,
    board_detect_if.master                   bus
);
    localparam int TYPE_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
    localparam int MAX_AB = (SETTLE_CYCLES > STABLE_SAMPLES) ? SETTLE_CYCLES : STABLE_SAMPLES;
    localparam int MAX_CD = (TIMEOUT_CYCLES > RECHECK_CYCLES) ? TIMEOUT_CYCLES : RECHECK_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_SAMPLE,
        S_MATCH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IO_WIDTH-1:0]   sync_meta;
    logic [IO_WIDTH-1:0]   sync_io;
    logic [IO_WIDTH-1:0]   prev;
    logic                  primed;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      stab;
    logic [CNT_W-1:0]      tcnt;
    logic                  stable_hit;
    logic                  timeout_hit;
    logic [NUM_BOARDS-1:0] match_calc;
    logic [TYPE_W-1:0]     type_calc;
    logic                  amb_calc;

    // Two-flop synchroniser for the asynchronous IO pins.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_io   <= '0;
        end else begin
            sync_meta <= io_in;
            sync_io   <= sync_meta;
        end
    end

    // stab counts agreements with the previous sample, so STABLE_LAST
    // agreements mean STABLE_SAMPLES identical samples in a row. A stable
    // run wins over a timeout landing on the same cycle.
    assign stable_hit  = primed && (stab == STABLE_LAST);
    assign timeout_hit = (tcnt == TIMEOUT_LAST);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= S_SETTLE;
        else          state <= state_nxt;
    end

    // Rescan overrides every other transition, including the hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                if (stable_hit)       state_nxt = S_MATCH;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_MATCH:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_SETTLE;
        endcase
        if (bus.rescan) state_nxt = S_SETTLE;
    end

    // Signature match against the latched snapshot; only registered in MATCH,
    // so mask changes at any other time have no effect on the results.
    always_comb begin
        match_calc = '0;
        for (int k = 0; k < NUM_BOARDS; k++) begin
            match_calc[k] = ((bus.io_snapshot & zero_masks[k*IO_WIDTH +: IO_WIDTH]) == '0) &&
                            ((~bus.io_snapshot & one_masks[k*IO_WIDTH +: IO_WIDTH]) == '0);
        end
        type_calc = '0;
        for (int k = NUM_BOARDS - 1; k >= 0; k--) begin
            if (match_calc[k]) type_calc = TYPE_W'(k);
        end
        amb_calc = ($countones(match_calc) > 1);
    end

`ifdef BOARD_DETECT_RECHECK_EN
    localparam logic [CNT_W-1:0] RECHECK_LAST = CNT_W'(RECHECK_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;
    logic             changed_q;
    assign bus.changed = changed_q;
`else
    assign bus.changed = 1'b0;
`endif

    // Counters, sample tracking and result registers.
    // The snapshot takes 'prev', which holds the value the stable run agreed on.
    // Recheck is skipped after a timeout since no snapshot was ever captured.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= '0;
            stab            <= '0;
            tcnt            <= '0;
            primed          <= 1'b0;
            prev            <= '0;
            bus.io_snapshot <= '0;
            bus.match_vec   <= '0;
            bus.board_type  <= '0;
            bus.ambiguous   <= 1'b0;
            bus.stable_err  <= 1'b0;
`ifdef BOARD_DETECT_RECHECK_EN
            rcnt            <= '0;
            changed_q       <= 1'b0;
`endif
        end else if (bus.rescan) begin
            cnt             <= '0;
            stab            <= '0;
            tcnt            <= '0;
            primed          <= 1'b0;
            bus.io_snapshot <= '0;
            bus.match_vec   <= '0;
            bus.board_type  <= '0;
            bus.ambiguous   <= 1'b0;
            bus.stable_err  <= 1'b0;
`ifdef BOARD_DETECT_RECHECK_EN
            rcnt            <= '0;
            changed_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_SETTLE: begin
                    cnt    <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                    stab   <= '0;
                    tcnt   <= '0;
                    primed <= 1'b0;
`ifdef BOARD_DETECT_RECHECK_EN
                    rcnt   <= '0;
`endif
                end
                S_SAMPLE: begin
                    prev   <= sync_io;
                    primed <= 1'b1;
                    if (!timeout_hit) tcnt <= tcnt + 1'b1;
                    if (primed && !stable_hit)
                        stab <= (sync_io == prev) ? stab + 1'b1 : '0;
                    if (stable_hit) begin
                        bus.io_snapshot <= prev;
                    end else if (timeout_hit) begin
                        bus.stable_err <= 1'b1;
                        bus.match_vec  <= '0;
                    end
                end
                S_MATCH: begin
                    bus.match_vec  <= match_calc;
                    bus.board_type <= type_calc;
                    bus.ambiguous  <= amb_calc;
                end
                S_DONE: begin
`ifdef BOARD_DETECT_RECHECK_EN
                    if (!bus.stable_err) begin
                        if (rcnt == RECHECK_LAST) begin
                            rcnt <= '0;
                            if (sync_io != bus.io_snapshot) changed_q <= 1'b1;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Status flags follow the next state so busy/done line up with the state
    // register; they are registered so everything reads 0 while in reset.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.scan_count <= '0;
        end else begin
            bus.busy <= (state_nxt != S_DONE);
            bus.done <= (state_nxt == S_DONE);
            if ((state != S_DONE) && (state_nxt == S_DONE) && (bus.scan_count != 8'hFF))
                bus.scan_count <= bus.scan_count + 8'd1;
        end
    end

    assign bus.board_valid = bus.done & (|bus.match_vec);

endmodule

// File: tb/tb_board_detect_scan.sv
// Self-checking bench for board_detect_scan.
//
// Small configuration: 8 IO lines, 3 signatures, settle 16, stable 4,
// timeout 64, recheck 32. Directed scans push their hand-computed results
// into a queue; a monitor pops one entry on every rising edge of done and
// compares all result fields plus the latency from scan start.
module tb_board_detect_scan;
    localparam int IO_W    = 8;
    localparam int NB      = 3;
    localparam int SETTLE  = 16;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int RECHECK = 32;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  io_base = 8'h00;
    logic        tog_bit = 1'b0;
    logic        toggle_en = 1'b0;
    int          tog_phase = 0;
    logic [7:0]  io_in;
    logic [23:0] zero_masks;
    logic [23:0] one_masks;

    assign io_in = io_base ^ {7'b0, tog_bit};

    board_detect_if #(.IO_WIDTH(IO_W), .NUM_BOARDS(NB)) bus ();

    board_detect_scan #(
        .IO_WIDTH      (IO_W),
        .NUM_BOARDS    (NB),
        .SETTLE_CYCLES (SETTLE),
        .STABLE_SAMPLES(STABLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RECHECK_CYCLES(RECHECK)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .io_in     (io_in),
        .zero_masks(zero_masks),
        .one_masks (one_masks),
        .bus       (bus)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] mv;
        logic       valid;
        logic [1:0] bt;
        logic       amb;
        logic       err;
        logic [7:0] snap;
        logic [7:0] count;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   scan_start = 0;
    logic done_prev = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] mv, input logic valid, input logic [1:0] bt,
                            input logic amb, input logic err, input logic [7:0] snap,
                            input logic [7:0] count, input int lat);
        exp_t e;
        e.mv = mv; e.valid = valid; e.bt = bt; e.amb = amb; e.err = err;
        e.snap = snap; e.count = count; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [7:0] io, input logic [23:0] zm, input logic [23:0] om);
        io_base    = io;
        zero_masks = zm;
        one_masks  = om;
    endtask

    // Rescan is sampled on the next rising edge; the scan starts there.
    task automatic pulse_rescan();
        @(negedge sysclk);
        bus.rescan = 1'b1;
        scan_start = cyc + 1;
        @(negedge sysclk);
        bus.rescan = 1'b0;
    endtask

    task automatic wait_scoreboard(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge sysclk);
            t++;
        end
        if (sb.size() != 0) begin
            check_output("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: one expectation per rising edge of done.
    always @(negedge sysclk) begin
        exp_t e;
        if (bus.done && !done_prev) begin
            if (sb.size() == 0) begin
                check_output("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output("match_vec",   32'(bus.match_vec),   32'(e.mv));
                check_output("board_valid", 32'(bus.board_valid), 32'(e.valid));
                check_output("board_type",  32'(bus.board_type),  32'(e.bt));
                check_output("ambiguous",   32'(bus.ambiguous),   32'(e.amb));
                check_output("stable_err",  32'(bus.stable_err),  32'(e.err));
                check_output("io_snapshot", 32'(bus.io_snapshot), 32'(e.snap));
                check_output("scan_count",  32'(bus.scan_count),  32'(e.count));
                check_output("busy_in_done", 32'(bus.busy),       32'd0);
                check_output("latency",     32'(cyc - scan_start), 32'(e.lat));
            end
        end
        done_prev = bus.done;
    end

    // Bit-0 toggler: flips every 2 cycles so no 4-sample run can form.
    always @(negedge sysclk) begin
        if (toggle_en) begin
            tog_phase++;
            if (tog_phase % 2 == 0) tog_bit = ~tog_bit;
        end else begin
            tog_bit = 1'b0;
        end
    end

    // Mask sets: {b2, b1, b0}
    localparam logic [23:0] ZM_A = {8'h00, 8'h0F, 8'hFF};
    localparam logic [23:0] OM_A = {8'hFF, 8'hF0, 8'h00};
    localparam logic [23:0] ZM_B = {8'h00, 8'h0F, 8'h00};
    localparam logic [23:0] OM_B = {8'hFF, 8'hF0, 8'h00};

    initial begin
        int t;
        bus.rescan = 1'b0;
        apply_stimulus(8'hF0, ZM_A, OM_A);

        // Reset state
        repeat (3) @(negedge sysclk);
        check_output("rst_busy",       32'(bus.busy),        32'd0);
        check_output("rst_done",       32'(bus.done),        32'd0);
        check_output("rst_match_vec",  32'(bus.match_vec),   32'd0);
        check_output("rst_scan_count", 32'(bus.scan_count),  32'd0);
        check_output("rst_snapshot",   32'(bus.io_snapshot), 32'd0);
        check_output("rst_changed",    32'(bus.changed),     32'd0);

        // Scan 1: io F0, only b1 matches
        push_exp(3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 8'hF0, 8'd1, 22);
        reset_n    = 1'b1;
        scan_start = cyc;
        @(negedge sysclk);
        check_output("busy_after_reset", 32'(bus.busy), 32'd1);
        wait_scoreboard(60);

        // Masks changed in DONE must not affect results
        apply_stimulus(8'hFF, ZM_B, OM_B);
        repeat (3) @(negedge sysclk);
        check_output("hold_match_vec",  32'(bus.match_vec),  32'b010);
        check_output("hold_board_type", 32'(bus.board_type), 32'd1);

        // Scan 2: io FF, b0 (all-zero masks) and b2 match
        push_exp(3'b101, 1'b1, 2'd0, 1'b1, 1'b0, 8'hFF, 8'd2, 22);
        pulse_rescan();
        check_output("rescan_done_clear", 32'(bus.done), 32'd0);
        wait_scoreboard(60);

        // Scan 3: bit 0 toggles, sampling times out
        toggle_en = 1'b1;
        push_exp(3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 8'd3, SETTLE + TIMEOUT);
        pulse_rescan();
        wait_scoreboard(120);

        // Scan 4: rescan mid-SAMPLE restarts the scan
        toggle_en = 1'b0;
        apply_stimulus(8'hF0, ZM_A, OM_A);
        pulse_rescan();
        check_output("rescan_err_clear", 32'(bus.stable_err), 32'd0);
        check_output("rescan_busy",      32'(bus.busy),       32'd1);
        repeat (17) @(negedge sysclk);
        push_exp(3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 8'hF0, 8'd4, 22);
        pulse_rescan();
        check_output("midscan_busy",  32'(bus.busy),      32'd1);
        check_output("midscan_done",  32'(bus.done),      32'd0);
        check_output("midscan_match", 32'(bus.match_vec), 32'd0);
        wait_scoreboard(60);

        // Scan 5: async reset mid-SETTLE
        pulse_rescan();
        repeat (5) @(negedge sysclk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_busy",       32'(bus.busy),        32'd0);
        check_output("async_done",       32'(bus.done),        32'd0);
        check_output("async_scan_count", 32'(bus.scan_count),  32'd0);
        check_output("async_snapshot",   32'(bus.io_snapshot), 32'd0);
        @(negedge sysclk);
        push_exp(3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 8'hF0, 8'd1, 22);
        reset_n    = 1'b1;
        scan_start = cyc;
        wait_scoreboard(60);

        // IO change in DONE: recheck flags it only when built in
        io_base = 8'hF1;
        t = 0;
        while (bus.changed !== 1'b1 && t < 40) begin
            @(negedge sysclk);
            t++;
        end
`ifdef BOARD_DETECT_RECHECK_EN
        check_output("recheck_changed", 32'(bus.changed), 32'd1);
`else
        check_output("recheck_absent", 32'(bus.changed), 32'd0);
`endif
        check_output("recheck_type", 32'(bus.board_type), 32'd1);
        check_output("recheck_done", 32'(bus.done),       32'd1);

        // Scan 6: io F1 matches nothing; rescan clears changed
        push_exp(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 8'hF1, 8'd2, 22);
        pulse_rescan();
        check_output("rescan_changed_clear", 32'(bus.changed), 32'd0);
        wait_scoreboard(60);

        repeat (4) @(negedge sysclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
